// File: rtl/spi_reader_pkg.sv
// Shared defaults and sizing helpers for the spi_reader receive-only SPI slave.
package spi_reader_pkg;

    localparam int unsigned DEFAULT_DATA_WIDTH  = 8;
    localparam int unsigned DEFAULT_SYNC_STAGES = 2;

    // Bit-counter width; a one-bit word still needs a one-bit counter.
    function automatic int unsigned cnt_width(input int unsigned width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/spi_reader_sync_ff.sv
// Single-bit multi-stage synchroniser used for the asynchronous SPI pins.
module sync_ff #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    always_comb begin
        sync_d = STAGES'({sync_q, d});
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/spi_reader.sv
// Receive-only mode-0 SPI slave sampled in the clk domain; presents each word with a one-cycle strobe.
// Define SPI_TIMEOUT_EN to discard partial words after TIMEOUT_CYCLES idle clk cycles.
module spi_reader
    import spi_reader_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = DEFAULT_DATA_WIDTH,
    parameter int unsigned SYNC_STAGES    = DEFAULT_SYNC_STAGES,
    parameter int unsigned MSB_FIRST      = 0,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  spi_clk,
    input  logic                  mosi,
    output logic [DATA_WIDTH-1:0] data,
    output logic                  received
);

    localparam int unsigned             CNT_W    = cnt_width(DATA_WIDTH);
    localparam logic [CNT_W-1:0]        LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("spi_reader: SYNC_STAGES must be at least 2");
    end
    if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
        $error("spi_reader: TIMEOUT_CYCLES must be non-zero");
    end

    logic                  spi_clk_s;
    logic                  mosi_s;
    logic                  spi_clk_prev_q, spi_clk_prev_d;
    logic                  rise_c;
    logic                  timeout_c;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic                  done_q, done_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  received_q, received_d;

    sync_ff #(.STAGES(SYNC_STAGES)) u_sync_sclk (
        .clk (clk),
        .rst (rst),
        .d   (spi_clk),
        .q   (spi_clk_s)
    );

    sync_ff #(.STAGES(SYNC_STAGES)) u_sync_mosi (
        .clk (clk),
        .rst (rst),
        .d   (mosi),
        .q   (mosi_s)
    );

    assign rise_c = spi_clk_s & ~spi_clk_prev_q;

`ifdef SPI_TIMEOUT_EN
    localparam int unsigned          IDLE_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IDLE_W-1:0]    IDLE_MAX = IDLE_W'(TIMEOUT_CYCLES);

    logic [IDLE_W-1:0] idle_q, idle_d;

    // Saturating count of clk cycles since the last spi_clk rise.
    always_comb begin
        idle_d = idle_q;
        if (rise_c) begin
            idle_d = '0;
        end else if (idle_q != IDLE_MAX) begin
            idle_d = idle_q + IDLE_W'(1);
        end
    end

    assign timeout_c = (idle_q == IDLE_MAX) && (bit_cnt_q != '0) && !rise_c;

    always_ff @(posedge clk) begin
        if (rst) begin
            idle_q <= '0;
        end else begin
            idle_q <= idle_d;
        end
    end
`else
    assign timeout_c = 1'b0;
`endif

    // Shift/count on each rise; completion is flagged one cycle ahead of the output load.
    always_comb begin
        spi_clk_prev_d = spi_clk_s;
        shift_d        = shift_q;
        bit_cnt_d      = bit_cnt_q;
        done_d         = 1'b0;
        if (rise_c) begin
            if (MSB_FIRST != 0) begin
                shift_d = DATA_WIDTH'({shift_q, mosi_s});
            end else begin
                shift_d = DATA_WIDTH'({mosi_s, shift_q} >> 1);
            end
            if (bit_cnt_q == LAST_BIT) begin
                bit_cnt_d = '0;
                done_d    = 1'b1;
            end else begin
                bit_cnt_d = bit_cnt_q + CNT_W'(1);
            end
        end else if (timeout_c) begin
            shift_d   = '0;
            bit_cnt_d = '0;
        end
    end

    always_comb begin
        data_d     = done_q ? shift_q : data_q;
        received_d = done_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            spi_clk_prev_q <= 1'b0;
            shift_q        <= '0;
            bit_cnt_q      <= '0;
            done_q         <= 1'b0;
            data_q         <= '0;
            received_q     <= 1'b0;
        end else begin
            spi_clk_prev_q <= spi_clk_prev_d;
            shift_q        <= shift_d;
            bit_cnt_q      <= bit_cnt_d;
            done_q         <= done_d;
            data_q         <= data_d;
            received_q     <= received_d;
        end
    end

    assign data     = data_q;
    assign received = received_q;

endmodule

// File: tb/tb_spi_reader.sv
// Directed bench for spi_reader: LSB-first and MSB-first instances share one SPI stream.
module tb_spi_reader;

    logic       clk;
    logic       rst;
    logic       spi_clk;
    logic       mosi;
    logic [7:0] data_l;
    logic [7:0] data_m;
    logic       received_l;
    logic       received_m;

    int checks;
    int failures;
    int consec;
    int strobes_m;
    logic prev_l;
    logic prev_m;
    logic [7:0] log_l[$];
    int base;

    spi_reader #(.DATA_WIDTH(8), .SYNC_STAGES(2), .MSB_FIRST(0), .TIMEOUT_CYCLES(16)) dut_lsb (
        .clk      (clk),
        .rst      (rst),
        .spi_clk  (spi_clk),
        .mosi     (mosi),
        .data     (data_l),
        .received (received_l)
    );

    spi_reader #(.DATA_WIDTH(8), .SYNC_STAGES(2), .MSB_FIRST(1), .TIMEOUT_CYCLES(16)) dut_msb (
        .clk      (clk),
        .rst      (rst),
        .spi_clk  (spi_clk),
        .mosi     (mosi),
        .data     (data_m),
        .received (received_m)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Strobe monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (received_l) begin
            log_l.push_back(data_l);
            if (prev_l) consec++;
        end
        if (received_m) begin
            strobes_m++;
            if (prev_m) consec++;
        end
        prev_l = received_l;
        prev_m = received_m;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One bit: mosi set half a clk before the rise, 2 clk high, 2 clk low.
    task automatic send_bit(input logic b);
        mosi = b;
        #5;
        spi_clk = 1'b1;
        #20;
        spi_clk = 1'b0;
        #15;
    endtask

    task automatic send_byte_lsb(input logic [7:0] v);
        for (int i = 0; i < 8; i++) send_bit(v[i]);
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        consec    = 0;
        strobes_m = 0;
        prev_l    = 1'b0;
        prev_m    = 1'b0;
        rst       = 1'b1;
        spi_clk   = 1'b1;
        mosi      = 1'b0;

        // Reset with spi_clk high, then release.
        @(posedge clk);
        #2;
        check("reset_data_lsb", 32'(data_l), 32'h00);
        check("reset_data_msb", 32'(data_m), 32'h00);
        check("reset_rcv_lsb", 32'(received_l), 32'h0);
        check("reset_rcv_msb", 32'(received_m), 32'h0);
        rst     = 1'b0;
        spi_clk = 1'b0;
        #100;
        check("no_strobe_after_reset", 32'(log_l.size()), 32'd0);

        // Single byte, bits 1,1,0,0,1,0,1,1 in send order.
        send_bit(1); send_bit(1); send_bit(0); send_bit(0);
        send_bit(1); send_bit(0); send_bit(1); send_bit(1);
        #100;
        check("single_strobes_lsb", 32'(log_l.size()), 32'd1);
        check("single_strobes_msb", 32'(strobes_m), 32'd1);
        check("single_data_lsb", 32'(data_l), 32'hD3);
        check("single_data_msb", 32'(data_m), 32'hCB);

        // Back-to-back bytes.
        base = log_l.size();
        send_byte_lsb(8'hA5);
        send_byte_lsb(8'h3C);
        #100;
        check("b2b_strobes", 32'(log_l.size() - base), 32'd2);
        if (log_l.size() >= base + 1) check("b2b_first", 32'(log_l[base]), 32'hA5);
        check("b2b_second_lsb", 32'(data_l), 32'h3C);
        check("b2b_second_msb", 32'(data_m), 32'h3C);

        // Reset mid-word discards the partial word and clears data.
        for (int i = 0; i < 5; i++) send_bit(1);
        #60;
        rst = 1'b1;
        #10;
        rst = 1'b0;
        #2;
        check("midrst_data_lsb", 32'(data_l), 32'h00);
        check("midrst_data_msb", 32'(data_m), 32'h00);
        #40;
        base = log_l.size();
        send_byte_lsb(8'h81);
        #100;
        check("midrst_strobes", 32'(log_l.size() - base), 32'd1);
        check("midrst_data", 32'(data_l), 32'h81);

        // Partial word followed by a long idle gap.
        base = log_l.size();
        send_bit(1); send_bit(0); send_bit(1);
        #200;
        check("idle_no_strobe", 32'(log_l.size() - base), 32'd0);
`ifdef SPI_TIMEOUT_EN
        send_byte_lsb(8'h5A);
        #100;
        check("timeout_strobes", 32'(log_l.size() - base), 32'd1);
        check("timeout_data_lsb", 32'(data_l), 32'h5A);
        check("timeout_data_msb", 32'(data_m), 32'h5A);
`else
        send_bit(1); send_bit(1); send_bit(0); send_bit(0); send_bit(0);
        #100;
        check("wait_strobes", 32'(log_l.size() - base), 32'd1);
        check("wait_data_lsb", 32'(data_l), 32'h1D);
        check("wait_data_msb", 32'(data_m), 32'hB8);
`endif

        check("no_consecutive_strobes", 32'(consec), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
